// File: rtl/pipe_pkg.sv
// Shared fetch-pipeline definitions: widths, PC step and the prefetch
// queue entry layout {instr, pc_plus4}.
package pipe_pkg;

  localparam int XLEN_DEF = 32;
  localparam int INSTR_W  = 32;
  localparam int PC_STEP  = 4;

  // Queue entry at the default address width. The prefetch unit packs its
  // queue words in this same field order for any XLEN.
  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [XLEN_DEF-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Prefetch instruction queue: power-of-two circular buffer with
// push/pop/flush and an occupancy count. Read data is forced to zero while
// the queue is empty so downstream never sees stale words.
module if_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  // Next-state for pointers and occupancy; flush discards everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only visible through the empty gating.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetch unit. Issues word fetches ahead of IF/ID under
// a credit limit (queued + in-flight < DEPTH), buffers in-order responses in
// if_fetch_fifo and handles redirects by flushing the queue and discarding
// responses still in flight.
// Optional build macro IF_PERF_CNT_EN enables the stall/flush performance
// counters; without it both counter ports are tied to zero.
//
// Handshakes: a fetch transfers on a cycle with imem_req_o && imem_gnt_i; a
// response is a single-cycle imem_rvalid_i pulse, in request order; an
// instruction leaves the queue on a cycle with out_valid_o && out_ready_i
// (ignored while redirect_i is high). out_valid_o never depends on
// out_ready_i.
module if_prefetch_unit
  import pipe_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_n,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [XLEN-1:0]    out_pc_plus4_o,
  output logic [31:0]        perf_stall_cnt_o,
  output logic [31:0]        perf_flush_cnt_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTR_W + XLEN;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;  // next address to request
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;    // address of next kept response
  logic [CW-1:0]   outst_q, outst_d;        // granted, not yet answered
  logic [CW-1:0]   discard_q, discard_d;    // in-flight responses to drop
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_flight;
  logic [EW-1:0]   fifo_wdata;
  logic [EW-1:0]   fifo_rdata;
  logic            fifo_empty;
  logic            grant;
  logic            drop;
  logic            push;
  logic            pop;

  // Credits count both queued and in-flight words, so the queue cannot
  // overflow. Reset gating keeps the request low while rst_n is asserted.
  assign in_flight  = {1'b0, fifo_count} + {1'b0, outst_q};
  assign imem_req_o = rst_n && !redirect_i && (in_flight < (CW+1)'(DEPTH));
  assign grant      = imem_req_o && imem_gnt_i;
  assign drop       = imem_rvalid_i && (redirect_i || (discard_q != '0));
  assign push       = imem_rvalid_i && !drop;
  assign pop        = out_valid_o && out_ready_i && !redirect_i;
  assign fifo_wdata = {imem_rdata_i, resp_pc_q + XLEN'(PC_STEP)};

  // Fetch/response PC tracking and in-flight bookkeeping. On redirect every
  // response still outstanding after this cycle becomes a discard, which
  // also covers discards left over from an earlier redirect.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CW'(grant) - CW'(imem_rvalid_i);
    discard_d  = discard_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      resp_pc_d  = redirect_pc_i;
      discard_d  = outst_q - CW'(imem_rvalid_i);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      if (push)  resp_pc_d  = resp_pc_q + XLEN'(PC_STEP);
      if (drop)  discard_d  = discard_q - CW'(1);
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  if_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign imem_addr_o    = fetch_pc_q;
  assign out_valid_o    = !fifo_empty;
  assign out_instr_o    = fifo_rdata[EW-1:XLEN];
  assign out_pc_plus4_o = fifo_rdata[XLEN-1:0];

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters: IF/ID stall cycles and redirect cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (redirect_i && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: streaming fetch, back-pressure,
// redirects with stale responses, PC wrap from a high RESET_PC and
// mid-stream asynchronous reset. Works with or without IF_PERF_CNT_EN.
module tb_if_prefetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_plus4_o;
  logic [31:0] perf_stall_cnt_o;
  logic [31:0] perf_flush_cnt_o;

  // Second instance with a high reset PC to observe address wrap.
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic [31:0] w_stall;
  logic [31:0] w_flush;

  int checks = 0;
  int errors = 0;
  int grants = 0;
  logic resp_en = 1'b0;

  logic [31:0] mem_q[$];   // granted addresses awaiting a response
  logic [31:0] exp_q[$];   // expected out_pc_plus4_o of accepted pops
  logic [31:0] addr_q[$];  // expected fetch addresses of grants

`ifdef IF_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd9;
  localparam logic [31:0] EXP_FLUSH = 32'd1;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

  if_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_instr_o(out_instr_o), .out_pc_plus4_o(out_pc_plus4_o),
    .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o)
  );

  if_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk_i(clk_i), .rst_n(rst_n),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .out_valid_o(w_valid), .out_ready_i(out_ready_i),
    .out_instr_o(w_instr), .out_pc_plus4_o(w_pc4),
    .perf_stall_cnt_o(w_stall), .perf_flush_cnt_o(w_flush)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply reset, clear the bench model and release; returns at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; out_ready_i = 1'b0; resp_en = 1'b0;
    mem_q.delete(); exp_q.delete(); addr_q.delete();
    grants = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: memory model drives the response, then outputs are
  // sampled mid-cycle; returns at posedge+1 of the next cycle.
  task automatic cycle();
    logic [31:0] a;
    logic [31:0] e;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (resp_en && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = instr_of(a);
    end
    #1;
    if (imem_req_o && imem_gnt_i) begin
      grants++;
      mem_q.push_back(imem_addr_o);
      if (addr_q.size() > 0) begin
        e = addr_q.pop_front();
        check_eq("fetch_addr", imem_addr_o, e);
      end
    end
    if (out_valid_o && out_ready_i && !redirect_i && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("pc_plus4", out_pc_plus4_o, e);
      check_eq("instr", out_instr_o, instr_of(e - 32'd4));
    end
    if (!out_valid_o) begin
      check_eq("empty_instr_zero", out_instr_o, 32'h0);
      check_eq("empty_pc4_zero", out_pc_plus4_o, 32'h0);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset state while rst_n is held low
    rst_n = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_req", {31'd0, imem_req_o}, 32'd0);
    check_eq("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check_eq("rst_instr", out_instr_o, 32'd0);
    check_eq("rst_pc4", out_pc_plus4_o, 32'd0);
    check_eq("rst_stall", perf_stall_cnt_o, 32'd0);
    check_eq("rst_flush", perf_flush_cnt_o, 32'd0);

    // Streaming fetch, 1-cycle latency, no back-pressure; wrap instance
    do_reset();
    check_eq("reset_pc", imem_addr_o, 32'h0);
    check_eq("wrap_reset_pc", w_addr, 32'hFFFF_FFFC);
    imem_gnt_i = 1'b1; out_ready_i = 1'b1; resp_en = 1'b1;
    addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_q  = '{32'h4, 32'h8, 32'hC, 32'h10};
    cycle();
    check_eq("wrap_addr_after_grant", w_addr, 32'h0);
    cycle();
    check_eq("first_valid_latency", {31'd0, out_valid_o}, 32'd1);
    check_eq("wrap_valid", {31'd0, w_valid}, 32'd1);
    check_eq("wrap_pc4", w_pc4, 32'h0);
    repeat (6) cycle();
    check_eq("stream_exp_left", exp_q.size(), 32'd0);
    check_eq("stream_addr_left", addr_q.size(), 32'd0);

    // Back-pressure: 11 cycles with ready low fill the 4-entry queue
    do_reset();
    imem_gnt_i = 1'b1; out_ready_i = 1'b0; resp_en = 1'b1;
    repeat (11) cycle();
    check_eq("stall_grants", grants, 32'd4);
    check_eq("stall_req_low", {31'd0, imem_req_o}, 32'd0);
    check_eq("stall_valid", {31'd0, out_valid_o}, 32'd1);
    check_eq("stall_cnt", perf_stall_cnt_o, EXP_STALL);
    out_ready_i = 1'b1;
    exp_q = '{32'h4, 32'h8, 32'hC, 32'h10};
    repeat (6) cycle();
    check_eq("drain_exp_left", exp_q.size(), 32'd0);

    // Redirect to 0x100 with two requests outstanding
    do_reset();
    imem_gnt_i = 1'b1; out_ready_i = 1'b1; resp_en = 1'b0;
    addr_q = '{32'h0, 32'h4};
    repeat (2) cycle();
    check_eq("two_outstanding", grants, 32'd2);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    cycle();
    check_eq("redirect_req_low", {31'd0, imem_req_o}, 32'd0);
    redirect_i = 1'b0; resp_en = 1'b1;
    addr_q = '{32'h100, 32'h104};
    exp_q  = '{32'h104, 32'h108};
    check_eq("flush_cnt", perf_flush_cnt_o, EXP_FLUSH);
    cycle();
    check_eq("stale0_dropped", {31'd0, out_valid_o}, 32'd0);
    cycle();
    check_eq("stale1_dropped", {31'd0, out_valid_o}, 32'd0);
    cycle();
    check_eq("redirect_first_valid", {31'd0, out_valid_o}, 32'd1);
    check_eq("redirect_first_pc4", out_pc_plus4_o, 32'h104);
    repeat (3) cycle();
    check_eq("redirect_exp_left", exp_q.size(), 32'd0);

    // Redirect coinciding with a response and a pop
    do_reset();
    imem_gnt_i = 1'b1; out_ready_i = 1'b1; resp_en = 1'b1;
    exp_q = '{32'h4, 32'h8, 32'h204};
    repeat (4) cycle();
    check_eq("pre_redirect_head", out_pc_plus4_o, 32'hC);
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    cycle();
    check_eq("coincide_empty", {31'd0, out_valid_o}, 32'd0);
    redirect_i = 1'b0;
    addr_q = '{32'h200};
    cycle();
    check_eq("coincide_still_empty", {31'd0, out_valid_o}, 32'd0);
    repeat (3) cycle();
    check_eq("coincide_exp_left", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of a stream
    do_reset();
    imem_gnt_i = 1'b1; out_ready_i = 1'b1; resp_en = 1'b1;
    repeat (5) cycle();
    check_eq("midstream_valid", {31'd0, out_valid_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_valid", {31'd0, out_valid_o}, 32'd0);
    check_eq("async_instr", out_instr_o, 32'd0);
    check_eq("async_pc4", out_pc_plus4_o, 32'd0);
    check_eq("async_req", {31'd0, imem_req_o}, 32'd0);
    check_eq("async_addr", imem_addr_o, 32'h0);
    do_reset();
    imem_gnt_i = 1'b1; out_ready_i = 1'b1; resp_en = 1'b1;
    addr_q = '{32'h0, 32'h4};
    exp_q  = '{32'h4, 32'h8};
    repeat (5) cycle();
    check_eq("restart_exp_left", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
